// File: rtl/elevator_call_dispatcher_if.sv
// Bundle of call, floor-feedback and target signals between the call dispatcher
// and whoever drives the buttons and floor controller feedback.
interface elevator_call_dispatcher_if #(
    parameter int NUM_FLOORS = 15
);
    logic [NUM_FLOORS-1:0] call_req;
    logic [4:0]            current_floor;
    logic                  door_open;
    logic [4:0]            requested_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  busy;
    logic                  dir_up;
    logic                  served;
    logic [4:0]            served_floor;
    logic                  fault;

    modport master (
        output call_req, current_floor, door_open,
        input  requested_floor, pending, busy, dir_up, served, served_floor, fault
    );

    modport slave (
        input  call_req, current_floor, door_open,
        output requested_floor, pending, busy, dir_up, served, served_floor, fault
    );
endinterface

// File: rtl/elevator_call_dispatcher.sv
// Latches floor calls, picks the next target with a SCAN sweep, retires served
// calls on arrival, holds a door dwell and flags travel timeouts.
module elevator_call_dispatcher #(
    parameter int NUM_FLOORS     = 15,
    parameter int DWELL_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                        clk,
    input logic                        reset,
    elevator_call_dispatcher_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SELECT, TRAVEL, DWELL} state_t;

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [4:0]            reqFloor_q, reqFloor_d;
    logic                  dirUp_q, dirUp_d;
    logic                  served_q, served_d;
    logic [4:0]            servedFloor_q, servedFloor_d;
    logic                  fault_q, fault_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DW-1:0]         dwell_q, dwell_d;

    logic [NUM_FLOORS-1:0] clr;
    logic [NUM_FLOORS-1:0] tgtMask;
    logic                  arrived;
    logic [4:0]            upTgt, belowTgt, downTgt, aboveTgt;
    logic                  upHit, belowHit, downHit, aboveHit;

    // Candidate targets on each side of the car; the loop order makes the
    // last hit the lowest (descending scans) or highest (ascending scans).
    always_comb begin
        upTgt    = '0;
        aboveTgt = '0;
        downTgt  = '0;
        belowTgt = '0;
        upHit    = 1'b0;
        aboveHit = 1'b0;
        downHit  = 1'b0;
        belowHit = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (5'(i) >= bus.current_floor)) begin
                upHit = 1'b1;
                upTgt = 5'(i);
            end
            if (pending_q[i] && (5'(i) > bus.current_floor)) begin
                aboveHit = 1'b1;
                aboveTgt = 5'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (5'(i) <= bus.current_floor)) begin
                downHit = 1'b1;
                downTgt = 5'(i);
            end
            if (pending_q[i] && (5'(i) < bus.current_floor)) begin
                belowHit = 1'b1;
                belowTgt = 5'(i);
            end
        end
    end

    assign tgtMask = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << reqFloor_q;
    assign arrived = (bus.current_floor == reqFloor_q) && bus.door_open;

    always_comb begin
        state_d       = state_q;
        clr           = '0;
        reqFloor_d    = reqFloor_q;
        dirUp_d       = dirUp_q;
        served_d      = 1'b0;
        servedFloor_d = servedFloor_q;
        fault_d       = fault_q;
        timer_d       = timer_q;
        dwell_d       = dwell_q;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) state_d = SELECT;
            end
            SELECT: begin
                if (pending_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = '0;
                    state_d = TRAVEL;
                    if (dirUp_q) begin
                        if (upHit) reqFloor_d = upTgt;
                        else begin
                            dirUp_d    = 1'b0;
                            reqFloor_d = belowTgt;
                        end
                    end else begin
                        if (downHit) reqFloor_d = downTgt;
                        else begin
                            dirUp_d    = 1'b1;
                            reqFloor_d = aboveTgt;
                        end
                    end
                end
            end
            TRAVEL: begin
                if (arrived) begin
                    clr           = tgtMask;
                    served_d      = 1'b1;
                    servedFloor_d = reqFloor_q;
                    dwell_d       = DW'(DWELL_CYCLES - 1);
                    state_d       = DWELL;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fault_d = 1'b1;
                    clr     = tgtMask;
                    state_d = SELECT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DWELL: begin
                // The door is still open here, so a press for this floor is absorbed.
                clr = tgtMask;
                if ((bus.call_req & tgtMask) != '0) dwell_d = DW'(DWELL_CYCLES - 1);
                else if (dwell_q == '0) state_d = (pending_q != '0) ? SELECT : IDLE;
                else dwell_d = dwell_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        pending_d = (pending_q | bus.call_req) & ~clr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            reqFloor_q    <= '0;
            dirUp_q       <= 1'b1;
            served_q      <= 1'b0;
            servedFloor_q <= '0;
            fault_q       <= 1'b0;
            timer_q       <= '0;
            dwell_q       <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            reqFloor_q    <= reqFloor_d;
            dirUp_q       <= dirUp_d;
            served_q      <= served_d;
            servedFloor_q <= servedFloor_d;
            fault_q       <= fault_d;
            timer_q       <= timer_d;
            dwell_q       <= dwell_d;
        end
    end

    assign bus.requested_floor = reqFloor_q;
    assign bus.pending         = pending_q;
    assign bus.busy            = (state_q != IDLE);
    assign bus.dir_up          = dirUp_q;
    assign bus.served          = served_q;
    assign bus.served_floor    = servedFloor_q;
    assign bus.fault           = fault_q;
endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Self-checking bench for elevator_call_dispatcher: a selection vector table,
// directed corner sequences and randomized call sets against a sweep-order model.
module tb_elevator_call_dispatcher;
    localparam int NF = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    elevator_call_dispatcher_if #(.NUM_FLOORS(NF)) bus ();

    elevator_call_dispatcher #(
        .NUM_FLOORS(NF), .DWELL_CYCLES(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // Manual drive for directed tests, a simulated car for the random phase.
    logic [4:0] manFloor = '0;
    logic       manDoor  = 1'b0;
    logic [4:0] carFloor = '0;
    logic       carDoor  = 1'b1;
    bit         carEnable = 1'b0;
    bit         moving = 1'b0;
    int         carDelay = 0;
    int         gotQ[$];
    int         expQ[$];
    bit         modelDir;
    int         modelPos;

    assign bus.current_floor = carEnable ? carFloor : manFloor;
    assign bus.door_open     = carEnable ? carDoor : manDoor;

    // The car closes its door when given a new target and arrives a few cycles later.
    always @(negedge clk) begin
        if (carEnable) begin
            if (!moving && bus.requested_floor != carFloor) begin
                moving   = 1'b1;
                carDoor  = 1'b0;
                carDelay = $urandom_range(1, 8);
            end else if (moving) begin
                if (carDelay == 0) begin
                    carFloor = bus.requested_floor;
                    carDoor  = 1'b1;
                    moving   = 1'b0;
                end else begin
                    carDelay--;
                end
            end
            if (bus.served) gotQ.push_back(int'(bus.served_floor));
        end
    end

    typedef struct {
        logic [4:0]    cf;
        logic [NF-1:0] calls;
        int            expFloor;
        bit            expDir;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyReset();
        reset = 1'b1;
        bus.call_req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [NF-1:0] m);
        bus.call_req = m;
        @(negedge clk);
        bus.call_req = '0;
    endtask

    // Sweep order: keep going in the current direction from the car, then turn once.
    task automatic buildExpected(input logic [NF-1:0] m);
        bit turned = 1'b0;
        expQ.delete();
        if (modelDir) begin
            for (int f = modelPos; f < NF; f++) if (m[f]) expQ.push_back(f);
            for (int f = modelPos - 1; f >= 0; f--) if (m[f]) begin
                expQ.push_back(f);
                turned = 1'b1;
            end
        end else begin
            for (int f = modelPos; f >= 0; f--) if (m[f]) expQ.push_back(f);
            for (int f = modelPos + 1; f < NF; f++) if (m[f]) begin
                expQ.push_back(f);
                turned = 1'b1;
            end
        end
        if (turned) modelDir = ~modelDir;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NF-1:0] m;
        bus.call_req = '0;

        vecs[0] = '{5'd0,  15'h0020, 5,  1'b1};
        vecs[1] = '{5'd6,  15'h1204, 9,  1'b1};
        vecs[2] = '{5'd6,  15'h0014, 4,  1'b0};
        vecs[3] = '{5'd6,  15'h0042, 6,  1'b1};
        vecs[4] = '{5'd14, 15'h2001, 13, 1'b0};
        vecs[5] = '{5'd20, 15'h4008, 14, 1'b0};
        vecs[6] = '{5'd0,  15'h4000, 14, 1'b1};
        vecs[7] = '{5'd10, 15'h0001, 0,  1'b0};

        applyReset();
        checkOutput("reset_req", bus.requested_floor, 0);
        checkOutput("reset_pending", bus.pending, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_dir", bus.dir_up, 1);
        checkOutput("reset_fault", bus.fault, 0);

        for (int v = 0; v < 8; v++) begin
            applyReset();
            manFloor = vecs[v].cf;
            manDoor  = 1'b0;
            applyStimulus(vecs[v].calls);
            @(negedge clk);
            checkOutput("vec_latency", bus.requested_floor, 0);
            @(negedge clk);
            checkOutput("vec_target", bus.requested_floor, vecs[v].expFloor);
            checkOutput("vec_dir", bus.dir_up, vecs[v].expDir);
            checkOutput("vec_busy", bus.busy, 1);
            checkOutput("vec_pending", bus.pending, vecs[v].calls);
        end

        // Basic serve, dwell length, then asynchronous reset mid-travel.
        applyReset();
        manFloor = 0; manDoor = 1'b0;
        applyStimulus(15'h0020);
        repeat (2) @(negedge clk);
        checkOutput("basic_target", bus.requested_floor, 5);
        manFloor = 5; manDoor = 1'b1;
        @(negedge clk);
        checkOutput("basic_served", bus.served, 1);
        checkOutput("basic_served_floor", bus.served_floor, 5);
        checkOutput("basic_pending", bus.pending, 0);
        @(negedge clk);
        checkOutput("basic_served_pulse", bus.served, 0);
        repeat (2) @(negedge clk);
        checkOutput("basic_dwell_busy", bus.busy, 1);
        @(negedge clk);
        checkOutput("basic_idle", bus.busy, 0);
        manDoor = 1'b0;
        applyStimulus(15'h0410);
        repeat (2) @(negedge clk);
        checkOutput("areset_pre_target", bus.requested_floor, 10);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("areset_req", bus.requested_floor, 0);
        checkOutput("areset_pending", bus.pending, 0);
        checkOutput("areset_busy", bus.busy, 0);
        checkOutput("areset_dir", bus.dir_up, 1);
        checkOutput("areset_served", bus.served, 0);
        checkOutput("areset_served_floor", bus.served_floor, 0);
        checkOutput("areset_fault", bus.fault, 0);
        #1 reset = 1'b0;

        // Press on the floor being retired, then a re-press during dwell.
        applyReset();
        manFloor = 0; manDoor = 1'b0;
        applyStimulus(15'h0200);
        repeat (2) @(negedge clk);
        checkOutput("clr_target", bus.requested_floor, 9);
        manFloor = 9; manDoor = 1'b1;
        bus.call_req = 15'h0200;
        @(negedge clk);
        bus.call_req = '0;
        checkOutput("clr_wins_pending", bus.pending, 0);
        checkOutput("clr_served", bus.served, 1);
        @(negedge clk);
        bus.call_req = 15'h0200;
        @(negedge clk);
        bus.call_req = '0;
        checkOutput("reopen_no_served", bus.served, 0);
        checkOutput("reopen_pending", bus.pending, 0);
        repeat (2) @(negedge clk);
        checkOutput("reopen_still_dwell", bus.busy, 1);
        repeat (2) @(negedge clk);
        checkOutput("reopen_idle", bus.busy, 0);

        // Travel timeout: target 7 never reached, then floor 1 is chosen going down.
        applyReset();
        manFloor = 3; manDoor = 1'b0;
        applyStimulus(15'h0082);
        repeat (2) @(negedge clk);
        checkOutput("to_target", bus.requested_floor, 7);
        repeat (63) @(negedge clk);
        checkOutput("to_not_yet", bus.fault, 0);
        @(negedge clk);
        checkOutput("to_fault", bus.fault, 1);
        checkOutput("to_pending", bus.pending, 15'h0002);
        checkOutput("to_no_served", bus.served, 0);
        @(negedge clk);
        checkOutput("to_next_target", bus.requested_floor, 1);
        checkOutput("to_next_dir", bus.dir_up, 0);
        repeat (10) @(negedge clk);
        checkOutput("to_fault_sticky", bus.fault, 1);

        // Call for the floor the car already stands at with its door open.
        applyReset();
        manFloor = 8; manDoor = 1'b1;
        applyStimulus(15'h0100);
        repeat (2) @(negedge clk);
        checkOutput("same_target", bus.requested_floor, 8);
        checkOutput("same_not_yet", bus.served, 0);
        @(negedge clk);
        checkOutput("same_served", bus.served, 1);
        checkOutput("same_served_floor", bus.served_floor, 8);

        // Random call sets served by the simulated car.
        applyReset();
        carFloor = 0; carDoor = 1'b1; moving = 1'b0;
        carEnable = 1'b1;
        modelDir = 1'b1;
        modelPos = 0;
        for (int t = 0; t < 20; t++) begin
            bit done = 1'b0;
            m = 15'($urandom) & 15'($urandom);
            if (m == '0) m[$urandom_range(0, NF - 1)] = 1'b1;
            buildExpected(m);
            gotQ.delete();
            applyStimulus(m);
            repeat (2) @(negedge clk);
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk);
                if (!bus.busy) begin
                    done = 1'b1;
                    break;
                end
            end
            checkOutput("rand_complete", done, 1);
            checkOutput("rand_count", gotQ.size(), expQ.size());
            for (int i = 0; i < expQ.size(); i++)
                checkOutput("rand_order", (i < gotQ.size()) ? gotQ[i] : -1, expQ[i]);
            checkOutput("rand_dir", bus.dir_up, modelDir);
            checkOutput("rand_fault", bus.fault, 0);
            checkOutput("rand_pending", bus.pending, 0);
            modelPos = expQ[expQ.size() - 1];
        end
        carEnable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
